rr_grant_index_8: RTL and testbench

- Registered 8-way round-robin arbiter.
- Selects one of 8 requesters and presents the winner as a 3-bit binary index with a valid flag.
- Sits directly upstream of the 3-to-8 one-hot decoder/demux stage: gnt_idx drives the decoder select, and gnt_valid drives its data/enable input, so at most one one-hot enable is active at a time.
- Includes a hold-timeout so no requester can monopolise the grant.

---
 rtl/rr_grant_index_8.sv | 139 +++++++++++++
 tb/tb_rr_grant_index_8.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_index_8.sv
// rr_grant_index_8 -- registered 8-way round-robin arbiter with hold timeout.
//
// Picks one of eight level-sensitive requesters, searching from a rotating
// pointer, and presents the winner as a binary index for a downstream 3-to-8
// decoder. Every grant is followed by one mandatory dead cycle, so two
// decoder enables can never overlap or abut.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   req[7:0]  in   request vector, bit i = requester i
//   done      in   single-cycle release pulse from the current grantee
//   gnt_idx   out  binary index of the current grantee (registered)
//   gnt_valid out  gnt_idx is a live grant (registered)
//   timeout   out  one-cycle pulse on a forced release by the hold limit
//   busy      out  arbiter is in GRANT or GAP
//
// state | meaning
// IDLE  | no grant; arbitrate on every edge where any request is pending
// GRANT | gnt_idx owns the grant; watch done, req[gnt_idx] and the hold limit
// GAP   | one dead cycle after a release before arbitrating again

module rr_grant_index_8 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam bit               HOLD_EN   = (HOLD_MAX != 0);
    // Count value seen on the edge that ends the HOLD_MAX-th valid cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(HOLD_MAX);

    state_t           state, state_nxt;
    logic [2:0]       ptr, ptr_nxt;
    logic [2:0]       idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             busy_nxt;
    logic [2:0]       winner;
    logic             found;
    logic             release_now;

    // First set request at or after ptr; the 3-bit add wraps 7 -> 0.
    always_comb begin
        winner = 3'd0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr + 3'(i)]) begin
                winner = ptr + 3'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        idx_nxt     = gnt_idx;
        cnt_nxt     = cnt;
        valid_nxt   = gnt_valid;
        timeout_nxt = 1'b0;
        release_now = 1'b0;

        case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                if (found) begin
                    idx_nxt   = winner;
                    valid_nxt = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                // A normal release wins over a coincident timeout.
                if (done || !req[gnt_idx]) begin
                    release_now = 1'b1;
                end else if (HOLD_EN && (cnt == HOLD_LAST)) begin
                    release_now = 1'b1;
                    timeout_nxt = 1'b1;
                end else if (cnt != HOLD_SAT) begin
                    cnt_nxt = cnt + 1'b1;
                end
                if (release_now) begin
                    valid_nxt = 1'b0;
                    ptr_nxt   = gnt_idx + 3'd1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= '0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            cnt       <= cnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rr_grant_index_8.sv
module tb_rr_grant_index_8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    rr_grant_index_8 #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic       valid;
        logic       to;
        logic       busy;
    } exp_t;

    exp_t q[$];

    // Reference model: phase 0 idle, 1 granted, 2 dead cycle.
    int m_phase, m_ptr, m_idx, m_held;
    bit m_valid, m_to;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_idx = 0; m_held = 0; m_valid = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit rel;
        rel  = 0;
        m_to = 0;
        case (m_phase)
            0: begin
                m_valid = 0;
                for (int k = 0; k < 8; k++) begin
                    if (!m_valid && req[(m_ptr + k) % 8]) begin
                        m_idx   = (m_ptr + k) % 8;
                        m_valid = 1;
                        m_held  = 1;
                        m_phase = 1;
                    end
                end
            end
            1: begin
                if (done || !req[m_idx]) rel = 1;
                else if (HOLD != 0 && m_held == HOLD) begin
                    rel  = 1;
                    m_to = 1;
                end else m_held++;
                if (rel) begin
                    m_valid = 0;
                    m_ptr   = (m_idx + 1) % 8;
                    m_phase = 2;
                end
            end
            default: begin
                m_valid = 0;
                m_phase = 0;
            end
        endcase
    endtask

    // Drive inputs (caller is at a negedge), let one edge happen, record the
    // expected response, and return at the following negedge.
    task automatic cyc(input logic [7:0] r, input logic d);
        exp_t e;
        req  = r;
        done = d;
        @(posedge clk);
        model_step();
        e.idx   = 3'(m_idx);
        e.valid = m_valid;
        e.to    = m_to;
        e.busy  = (m_phase != 0);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold_reset();
        req  = 8'h00;
        done = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: compares each registered output set one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                chk("gnt_idx",   int'(gnt_idx),   int'(e.idx));
                chk("gnt_valid", int'(gnt_valid), int'(e.valid));
                chk("timeout",   int'(timeout),   int'(e.to));
                chk("busy",      int'(busy),      int'(e.busy));
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        model_reset();
        #2;
        chk("reset_valid", int'(gnt_valid), 0);
        chk("reset_idx",   int'(gnt_idx),   0);
        chk("reset_busy",  int'(busy),      0);
        chk("reset_to",    int'(timeout),   0);
        @(negedge clk);
        hold_reset();

        // idle with no requests
        repeat (10) cyc(8'h00, 1'b0);

        // single requester, done on its fourth granted cycle
        repeat (4) cyc(8'h10, 1'b0);
        cyc(8'h10, 1'b1);
        repeat (3) cyc(8'h10, 1'b0);
        cyc(8'h10, 1'b1);
        repeat (3) cyc(8'h00, 1'b0);

        // full rotation with done held high
        repeat (30) cyc(8'hFF, 1'b1);
        repeat (3) cyc(8'h00, 1'b0);

        // set ptr=6 via a grant to 5, then wrap and skip
        cyc(8'h20, 1'b0);
        cyc(8'h20, 1'b1);
        cyc(8'h00, 1'b0);
        repeat (8) cyc(8'h05, 1'b1);
        repeat (3) cyc(8'h00, 1'b0);

        // set ptr=1 via a grant to 0, then 7 before 0
        cyc(8'h01, 1'b0);
        cyc(8'h01, 1'b1);
        cyc(8'h00, 1'b0);
        repeat (8) cyc(8'h81, 1'b1);
        repeat (3) cyc(8'h00, 1'b0);

        // timeouts: two holders that never pulse done
        repeat (14) cyc(8'h09, 1'b0);
        repeat (3) cyc(8'h00, 1'b0);
        repeat (7) cyc(8'h08, 1'b0);
        repeat (3) cyc(8'h00, 1'b0);

        // withdraw during grant
        cyc(8'h04, 1'b0);
        cyc(8'h04, 1'b0);
        cyc(8'h00, 1'b0);
        repeat (2) cyc(8'h00, 1'b0);

        // done on the same edge as the hold limit
        repeat (4) cyc(8'h04, 1'b0);
        cyc(8'h04, 1'b1);
        repeat (3) cyc(8'h00, 1'b0);

        // asynchronous reset in the middle of a grant to 5
        cyc(8'h20, 1'b0);
        cyc(8'h20, 1'b0);
        chk("pre_rst_valid", int'(gnt_valid), 1);
        chk("pre_rst_idx",   int'(gnt_idx),   5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(gnt_valid), 0);
        chk("async_rst_idx",   int'(gnt_idx),   0);
        chk("async_rst_busy",  int'(busy),      0);
        @(negedge clk);
        hold_reset();
        repeat (10) cyc(8'h00, 1'b0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            r = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 7) == 0) r = 8'h00;
            cyc(r, ($urandom_range(0, 3) == 0));
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
